// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

    localparam int MAX_STAGES = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } rst_seq_state_t;

    // Width that holds the largest of three terminal counts without wrapping.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_lock_qual.sv
// Saturating consecutive-sample lock filter; lock_ok_o flags the edge on which
// the LOCK_FILT-th consecutive high sample is taken (and stays high while saturated).
module lock_qual #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic lock_i,
    output logic lock_ok_o
);
    import rst_seq_pkg::*;

    localparam int FW = $clog2(LOCK_FILT + 1);

    if (LOCK_FILT < 1) begin : g_bad_filt
        $error("lock_qual: LOCK_FILT must be >= 1");
    end

    logic [FW-1:0] cnt_reg;
    logic [FW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!en_i || !lock_i) begin
            cnt_next = '0;
        end else if (cnt_reg != FW'(LOCK_FILT)) begin
            cnt_next = cnt_reg + FW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Looks at the registered count so the sequencer can move on the qualifying edge.
    assign lock_ok_o = en_i && lock_i &&
                       ((cnt_reg == FW'(LOCK_FILT - 1)) || (cnt_reg == FW'(LOCK_FILT)));

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: waits for qualified lock, holds, then releases
// rst_o one stage at a time (bit 0 first), re-asserting on lock loss or sw request.
module rst_seq_ctrl #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_FILT   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DELAY = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lock_i,
    input  logic                  sw_rst_req_i,
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  rst_done_o,
    output logic                  seq_busy_o
);
    import rst_seq_pkg::*;

    localparam int CNT_W = cnt_width(LOCK_FILT, HOLD_CYCLES, STAGE_DELAY);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [NUM_STAGES-1:0] ONES = {NUM_STAGES{1'b1}};

    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("rst_seq_ctrl: NUM_STAGES must be in 1..16");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("rst_seq_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_delay
        $error("rst_seq_ctrl: STAGE_DELAY must be >= 1");
    end

    rst_seq_state_t        state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [NUM_STAGES-1:0] rst_reg, rst_next;
    logic                  done_reg, done_next;
    logic                  busy_reg, busy_next;
    logic                  lock_en;
    logic                  lock_ok;
    logic [NUM_STAGES-1:0] stage_sel;

    lock_qual #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_qual (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (lock_en),
        .lock_i    (lock_i),
        .lock_ok_o (lock_ok)
    );

    // One-hot select of the stage released next.
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
        assign stage_sel[gi] = (idx_reg == IDX_W'(gi));
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        rst_next   = rst_reg;
        done_next  = 1'b0;
        busy_next  = 1'b1;
        lock_en    = 1'b0;

        // Lock loss outranks everything, including a simultaneous sw request.
        if (state_reg != WAIT_LOCK && !lock_i) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            idx_next   = '0;
            rst_next   = ONES;
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    lock_en  = 1'b1;
                    rst_next = ONES;
                    cnt_next = '0;
                    idx_next = '0;
                    if (lock_ok) begin
                        state_next = HOLD;
                    end
                end

                HOLD: begin
                    rst_next = ONES;
                    if (sw_rst_req_i) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt_next = '0;
                        rst_next = ONES << 1;
                        if (NUM_STAGES == 1) begin
                            state_next = DONE;
                            idx_next   = '0;
                        end else begin
                            state_next = RELEASE;
                            idx_next   = IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    if (sw_rst_req_i) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        idx_next   = '0;
                        rst_next   = ONES;
                    end else if (cnt_reg == CNT_W'(STAGE_DELAY - 1)) begin
                        cnt_next = '0;
                        rst_next = rst_reg & ~stage_sel;
                        if (idx_reg == IDX_W'(NUM_STAGES - 1)) begin
                            state_next = DONE;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end

                DONE: begin
                    if (sw_rst_req_i) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        idx_next   = '0;
                        rst_next   = ONES;
                    end else begin
                        done_next = 1'b1;
                        busy_next = 1'b0;
                    end
                end

                default: begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    rst_next   = ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rst_reg   <= ONES;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rst_reg   <= rst_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign rst_o      = rst_reg;
    assign rst_done_o = done_reg;
    assign seq_busy_o = busy_reg;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a 3-stage and a 1-stage instance share stimulus;
// expected outputs come from the release timeline relative to HOLD entry.
module tb_rst_seq_ctrl;

    localparam int HOLD = 16;
    localparam int DLY  = 8;
    localparam int NEVER = 100000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       lock_i = 1'b0;
    logic       sw_rst_req_i = 1'b0;
    logic [2:0] rst3;
    logic       done3, busy3;
    logic [0:0] rst1;
    logic       done1, busy1;

    always #5 clk_i = ~clk_i;

    rst_seq_ctrl #(
        .NUM_STAGES (3), .LOCK_FILT (4), .HOLD_CYCLES (HOLD), .STAGE_DELAY (DLY)
    ) dut3 (
        .clk_i (clk_i), .rst_i (rst_i), .lock_i (lock_i), .sw_rst_req_i (sw_rst_req_i),
        .rst_o (rst3), .rst_done_o (done3), .seq_busy_o (busy3)
    );

    rst_seq_ctrl #(
        .NUM_STAGES (1), .LOCK_FILT (4), .HOLD_CYCLES (HOLD), .STAGE_DELAY (DLY)
    ) dut1 (
        .clk_i (clk_i), .rst_i (rst_i), .lock_i (lock_i), .sw_rst_req_i (sw_rst_req_i),
        .rst_o (rst1), .rst_done_o (done1), .seq_busy_o (busy1)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  rst3;
        logic        done3;
        logic        busy3;
        logic        rst1;
        logic        done1;
        logic        busy1;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    endtask

    // h = edge on which HOLD is entered with the hold count at 0.
    function automatic exp_t model(input int n, input int h);
        exp_t e;
        e.cyc = 32'(n);
        for (int k = 0; k < 3; k++) e.rst3[k] = (n < h + HOLD + DLY * k);
        e.done3 = (n >= h + HOLD + DLY * 2 + 1);
        e.busy3 = !e.done3;
        e.rst1  = (n < h + HOLD);
        e.done1 = (n >= h + HOLD + 1);
        e.busy1 = !e.done1;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty cyc=%0d got=0 entries exp=1 entry", cyc);
        end else begin
            e = sb_q.pop_front();
            $display("cyc=%0d lock=%b sw=%b rst=%b dut3.rst_o=%b done=%b busy=%b dut1.rst_o=%b done=%b busy=%b",
                     e.cyc, lock_i, sw_rst_req_i, rst_i, rst3, done3, busy3, rst1, done1, busy1);
            check_val("dut3.rst_o",       32'(rst3),  32'(e.rst3));
            check_val("dut3.rst_done_o",  32'(done3), 32'(e.done3));
            check_val("dut3.seq_busy_o",  32'(busy3), 32'(e.busy3));
            check_val("dut1.rst_o",       32'(rst1),  32'(e.rst1));
            check_val("dut1.rst_done_o",  32'(done1), 32'(e.done1));
            check_val("dut1.seq_busy_o",  32'(busy1), 32'(e.busy1));
        end
    endtask

    task automatic step(input logic lk, input logic sw, input int h);
        lock_i       = lk;
        sw_rst_req_i = sw;
        cyc++;
        sb_q.push_back(model(cyc, h));
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    // Asserts rst_i between edges, checks the async response, then releases on a falling edge.
    task automatic do_reset(input logic lk);
        rst_i        = 1'b1;
        lock_i       = lk;
        sw_rst_req_i = 1'b0;
        #1;
        sb_q.push_back(model(cyc, NEVER));
        check_out();
        repeat (2) @(posedge clk_i);
        #1;
        sb_q.push_back(model(cyc, NEVER));
        check_out();
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1111_0111;
        #2;

        // Defaults with lock held high, then sw request in DONE, then lock loss + sw together
        do_reset(1'b1);
        for (int n = 1; n <= 40; n++) step(1'b1, 1'b0, 4);
        step(1'b1, 1'b1, 41);
        for (int n = 42; n <= 76; n++) step(1'b1, 1'b0, 41);
        step(1'b0, 1'b1, NEVER);
        for (int n = 78; n <= 100; n++) step(1'b1, 1'b0, 81);

        // Lock filter restart on a dropped sample
        do_reset(1'b1);
        for (int n = 1; n <= 8; n++) step(pat[n-1], 1'b0, 8);
        for (int n = 9; n <= 42; n++) step(1'b1, 1'b0, 8);

        // Lock drop mid-RELEASE, recovery, then sw request during HOLD
        do_reset(1'b1);
        for (int n = 1; n <= 29; n++) step(1'b1, 1'b0, 4);
        step(1'b0, 1'b0, 34);
        for (int n = 31; n <= 39; n++) step(1'b1, 1'b0, 34);
        step(1'b1, 1'b1, 40);
        for (int n = 41; n <= 75; n++) step(1'b1, 1'b0, 40);

        // Async reset mid-HOLD and mid-RELEASE
        do_reset(1'b1);
        for (int n = 1; n <= 10; n++) step(1'b1, 1'b0, 4);
        do_reset(1'b1);
        for (int n = 1; n <= 30; n++) step(1'b1, 1'b0, 4);
        do_reset(1'b1);
        for (int n = 1; n <= 40; n++) step(1'b1, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
